// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM access scheduler.
//   - Default widths (AW_DEF, DW_DEF, BANK_W_DEF) and starvation limit.
//   - Grant encoding for the per-cycle access mux.
//   - States of the CPU capture/replay FSM.
//   - CPU_ADDR_XOR: the D/E decode mask applied to CPU addresses at the default width.
// Optional feature macro used by the top: VRAM_ARB_STATS_EN (CPU stall statistics).
package vram_arb_pkg;

  localparam int AW_DEF         = 13;
  localparam int DW_DEF         = 8;
  localparam int BANK_W_DEF     = 2;
  localparam int STARVE_MAX_DEF = 15;

  // Top address bit of the CPU window is inverted so the D/E decode lands on bank offset 0.
  localparam logic [AW_DEF-1:0] CPU_ADDR_XOR = 13'h1000;

  typedef enum logic [2:0] {
    GNT_NONE = 3'd0,
    GNT_VID  = 3'd1,
    GNT_CPU  = 3'd2,
    GNT_HOLD = 3'd3,
    GNT_DMA  = 3'd4
  } grant_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } hold_state_t;

endpackage

// File: rtl/vram_arb_hold.sv
// CPU capture/replay stage of the VRAM scheduler.
// Owns the IDLE/HELD FSM, the held-access register and cpu_rdy.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_sel/we/addr/din live CPU access (address not yet D/E decoded)
//   blocked             a higher-priority requester (video or forced DMA) owns this cycle
//   cpu_rdy             registered ready; low while an access sits in the hold register
//   cpu_gnt             a CPU access (live or replayed) is issued this cycle
//   cpu_from_hold       the issued/pending CPU access comes from the hold register
//   acc_we/addr/din     the CPU access presented to the mux (decoded address)
module vram_arb_hold
  import vram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          blocked,
  output logic          cpu_rdy,
  output logic          cpu_gnt,
  output logic          cpu_from_hold,
  output logic          acc_we,
  output logic [AW-1:0] acc_addr,
  output logic [DW-1:0] acc_din
);

  localparam logic [AW-1:0] ADDR_XOR =
      (AW == AW_DEF) ? AW'(CPU_ADDR_XOR) : (AW'(1) << (AW - 1));

  hold_state_t   state_reg;
  logic          hold_we_reg;
  logic [AW-1:0] hold_addr_reg;
  logic [DW-1:0] hold_din_reg;
  logic          rdy_reg;
  logic [AW-1:0] live_addr;

  assign live_addr     = cpu_addr ^ ADDR_XOR;
  assign cpu_from_hold = (state_reg == ST_HELD);
  assign cpu_rdy       = rdy_reg;

  // While HELD the CPU is repeating the stalled access, so the live inputs are
  // ignored; only the hold register is ever replayed (prevents a double write).
  assign cpu_gnt  = !blocked && (cpu_from_hold || cpu_sel);
  assign acc_we   = cpu_from_hold ? hold_we_reg   : cpu_we;
  assign acc_addr = cpu_from_hold ? hold_addr_reg : live_addr;
  assign acc_din  = cpu_from_hold ? hold_din_reg  : cpu_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      hold_we_reg   <= 1'b0;
      hold_addr_reg <= '0;
      hold_din_reg  <= '0;
      rdy_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cpu_sel && blocked) begin
            hold_we_reg   <= cpu_we;
            hold_addr_reg <= live_addr;
            hold_din_reg  <= cpu_din;
            state_reg     <= ST_HELD;
            rdy_reg       <= 1'b0;
          end
        end
        ST_HELD: begin
          if (!blocked) begin
            state_reg <= ST_IDLE;
            rdy_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          rdy_reg   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM access scheduler for video fetch, CPU and DMA/fill engine.
// Priority per cycle: video > forced DMA > held CPU > live CPU > DMA.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   bank                               bank select prepended to every VRAM address
//   vid_req, vid_addr                  video fetch, served in the request cycle
//   cpu_sel/we/addr/din, cpu_rdy       CPU access with stall handshake
//   cpu_rvalid                         VRAM dout carries CPU read data this cycle
//   dma_req/we/addr/din, dma_ack       DMA access, one-cycle combinational grant
//   dma_rvalid                         VRAM dout carries DMA read data this cycle
//   mem_we, mem_addr, mem_din          VRAM macro interface
//   stall_cnt, stall_clr               CPU stall-cycle statistics
// Optional feature: define VRAM_ARB_STATS_EN to build the stall counter; otherwise
// stall_cnt reads 16'h0000 and stall_clr has no effect.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int BANK_W     = BANK_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BANK_W-1:0]    bank,
  input  logic                 vid_req,
  input  logic [AW-1:0]        vid_addr,
  input  logic                 cpu_sel,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_din,
  output logic                 cpu_rdy,
  output logic                 cpu_rvalid,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [AW-1:0]        dma_addr,
  input  logic [DW-1:0]        dma_din,
  output logic                 dma_ack,
  output logic                 dma_rvalid,
  output logic                 mem_we,
  output logic [BANK_W+AW-1:0] mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic [15:0]          stall_cnt,
  input  logic                 stall_clr
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  grant_t        gnt;
  logic          forced;
  logic          blocked;
  logic          cpu_gnt;
  logic          cpu_from_hold;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_din;
  logic [7:0]    starve_reg;
  logic          cpu_rvalid_reg;
  logic          dma_rvalid_reg;

  assign forced  = dma_req && (starve_reg == STARVE_LIM);
  assign blocked = vid_req || forced;

  vram_arb_hold #(.AW(AW), .DW(DW)) u_hold (
    .clk           (clk),
    .reset         (reset),
    .cpu_sel       (cpu_sel),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .blocked       (blocked),
    .cpu_rdy       (cpu_rdy),
    .cpu_gnt       (cpu_gnt),
    .cpu_from_hold (cpu_from_hold),
    .acc_we        (acc_we),
    .acc_addr      (acc_addr),
    .acc_din       (acc_din)
  );

  // Nothing is granted during reset, so a held write cannot reach the VRAM.
  always_comb begin
    gnt = GNT_NONE;
    if (reset)        gnt = GNT_NONE;
    else if (vid_req) gnt = GNT_VID;
    else if (forced)  gnt = GNT_DMA;
    else if (cpu_gnt) gnt = cpu_from_hold ? GNT_HOLD : GNT_CPU;
    else if (dma_req) gnt = GNT_DMA;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (gnt)
      GNT_VID:  mem_addr = {bank, vid_addr};
      GNT_CPU, GNT_HOLD: begin
        mem_we   = acc_we;
        mem_addr = {bank, acc_addr};
        mem_din  = acc_din;
      end
      GNT_DMA: begin
        mem_we   = dma_we;
        mem_addr = {bank, dma_addr};
        mem_din  = dma_din;
      end
      default: ;
    endcase
  end

  assign dma_ack    = (gnt == GNT_DMA);
  assign cpu_rvalid = cpu_rvalid_reg;
  assign dma_rvalid = dma_rvalid_reg;

  // Starvation counter saturates at the limit so the forced condition stays
  // asserted while video keeps the bus.
  always_ff @(posedge clk) begin
    if (reset || !dma_req || dma_ack) starve_reg <= '0;
    else if (starve_reg != STARVE_LIM) starve_reg <= starve_reg + 8'd1;
  end

  // rvalid lines up with the VRAM's registered dout one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      cpu_rvalid_reg <= ((gnt == GNT_CPU) || (gnt == GNT_HOLD)) && !acc_we;
      dma_rvalid_reg <= (gnt == GNT_DMA) && !dma_we;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || stall_clr) stall_cnt_reg <= '0;
    else if (!cpu_rdy && (stall_cnt_reg != 16'hFFFF)) stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: inputs change just after the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int BW = 2;

`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] bank;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          cpu_sel, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_rdy, cpu_rvalid;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_din;
  logic          dma_ack, dma_rvalid;
  logic          mem_we;
  logic [BW+AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [15:0]   stall_cnt;
  logic          stall_clr;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int wr_mark;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .bank(bank),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_rdy(cpu_rdy), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  // Count VRAM writes actually committed at the rising edge.
  always @(posedge clk) if (mem_we === 1'b1) wr_count <= wr_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle's drive point.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bank = 2'b01;
    vid_req = 0; vid_addr = '0;
    cpu_sel = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
    stall_clr = 0;
    repeat (3) @(negedge clk);

    // Reset state
    reset = 1'b0; settle();
    check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);

    // 1: CPU write 0x1234 <- 0x5A on an idle bus, issued same cycle
    next_cycle();
    cpu_sel = 1; cpu_we = 1; cpu_addr = 13'h1234; cpu_din = 8'h5A; settle();
    check("t1_mem_we", 32'(mem_we), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h2234);
    check("t1_mem_din", 32'(mem_din), 32'h5A);
    check("t1_cpu_rdy", 32'(cpu_rdy), 32'd1);
    next_cycle();
    cpu_sel = 0; settle();
    check("t1_rdy_after", 32'(cpu_rdy), 32'd1);
    check("t1_no_rvalid_wr", 32'(cpu_rvalid), 32'd0);

    // 2: video and CPU write collide; CPU captured then replayed once
    wr_mark = wr_count;
    next_cycle();
    vid_req = 1; vid_addr = 13'h0ABC;
    cpu_sel = 1; cpu_we = 1; cpu_addr = 13'h1010; cpu_din = 8'hA5; settle();
    check("t2_vid_addr", 32'(mem_addr), 32'h2ABC);
    check("t2_vid_we", 32'(mem_we), 32'd0);
    check("t2_rdy_c0", 32'(cpu_rdy), 32'd1);
    next_cycle();
    vid_req = 0; settle();
    check("t2_rdy_c1", 32'(cpu_rdy), 32'd0);
    check("t2_hold_we", 32'(mem_we), 32'd1);
    check("t2_hold_addr", 32'(mem_addr), 32'h2010);
    check("t2_hold_din", 32'(mem_din), 32'hA5);
    next_cycle();
    cpu_sel = 0; settle();
    check("t2_rdy_c2", 32'(cpu_rdy), 32'd1);
    check("t2_single_write", 32'(wr_count - wr_mark), 32'd1);
    check("t2_stall_cnt", 32'(stall_cnt), STATS ? 32'd1 : 32'd0);

    // 3: five video cycles during a CPU read
    next_cycle();
    stall_clr = 1; settle();
    next_cycle();
    stall_clr = 0;
    cpu_sel = 1; cpu_we = 0; cpu_addr = 13'h0500;
    for (int i = 0; i < 5; i++) begin
      vid_req = 1; vid_addr = 13'(13'h0040 + i); settle();
      check($sformatf("t3_vid_addr_%0d", i), 32'(mem_addr), 32'(15'h2040 + i));
      check($sformatf("t3_rdy_%0d", i), 32'(cpu_rdy), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("t3_rvalid_%0d", i), 32'(cpu_rvalid), 32'd0);
      next_cycle();
    end
    vid_req = 0; settle();
    check("t3_replay_addr", 32'(mem_addr), 32'h3500);
    check("t3_replay_we", 32'(mem_we), 32'd0);
    check("t3_replay_rdy", 32'(cpu_rdy), 32'd0);
    check("t3_replay_rvalid", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    cpu_sel = 0; settle();
    check("t3_rdy_back", 32'(cpu_rdy), 32'd1);
    check("t3_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t3_stall_cnt", 32'(stall_cnt), STATS ? 32'd5 : 32'd0);

    // 4: DMA write starved by back-to-back CPU reads
    next_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 13'h0200; dma_din = 8'h77;
    cpu_sel = 1; cpu_we = 0; cpu_addr = 13'h1300;
    for (int k = 0; k < 15; k++) begin
      settle();
      check($sformatf("t4_no_ack_%0d", k), 32'(dma_ack), 32'd0);
      check($sformatf("t4_cpu_addr_%0d", k), 32'(mem_addr), 32'h2300);
      next_cycle();
    end
    settle();
    check("t4_forced_ack", 32'(dma_ack), 32'd1);
    check("t4_forced_addr", 32'(mem_addr), 32'h2200);
    check("t4_forced_we", 32'(mem_we), 32'd1);
    check("t4_forced_din", 32'(mem_din), 32'h77);
    check("t4_rdy_c15", 32'(cpu_rdy), 32'd1);
    next_cycle();
    dma_req = 0; settle();
    check("t4_ack_pulse", 32'(dma_ack), 32'd0);
    check("t4_replay_rdy", 32'(cpu_rdy), 32'd0);
    check("t4_replay_addr", 32'(mem_addr), 32'h2300);
    check("t4_rvalid_gap", 32'(cpu_rvalid), 32'd0);
    check("t4_dma_rvalid_wr", 32'(dma_rvalid), 32'd0);
    next_cycle();
    cpu_sel = 0; settle();
    check("t4_rdy_back", 32'(cpu_rdy), 32'd1);
    check("t4_replay_rvalid", 32'(cpu_rvalid), 32'd1);

    // 5: reset while a write is held
    next_cycle();
    vid_req = 1; vid_addr = 13'h0001;
    cpu_sel = 1; cpu_we = 1; cpu_addr = 13'h1400; cpu_din = 8'h33;
    next_cycle();
    vid_req = 0; reset = 1; settle();
    wr_mark = wr_count;
    check("t5_we_in_reset", 32'(mem_we), 32'd0);
    next_cycle();
    reset = 0; cpu_sel = 0; settle();
    check("t5_rdy", 32'(cpu_rdy), 32'd1);
    check("t5_no_replay", 32'(mem_we), 32'd0);
    next_cycle();
    settle();
    check("t5_still_idle", 32'(mem_we), 32'd0);
    check("t5_write_lost", 32'(wr_count - wr_mark), 32'd0);

    // 6: DMA read on an idle bus
    next_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 13'h0100; settle();
    check("t6_ack", 32'(dma_ack), 32'd1);
    check("t6_addr", 32'(mem_addr), 32'h2100);
    check("t6_we", 32'(mem_we), 32'd0);
    next_cycle();
    dma_req = 0; settle();
    check("t6_ack_drop", 32'(dma_ack), 32'd0);
    check("t6_rvalid", 32'(dma_rvalid), 32'd1);
    check("t6_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
